tpu_mm_sequencer: RTL and testbench
===================================

# tpu_mm_sequencer

- Sequences one complete DIM×DIM matrix multiply on the tpuv1 MMIO datapath: optional C clear, load A, load B, start, compute wait, C readback.
- Sits between the host-side operand/result streams and the tpuv1 bus (`r_w` / `addr` / `dataIn` / `dataOut`) and is that bus's only master.
- The host never issues raw MMIO addresses.

## Interface
Parameters:
- DIM, 8, matrix dimension; rows of A, words of B, rows of C
- DATAW, 64, bus and stream data width
- ADDRW, 16, tpuv1 address width
- COMPUTE_CYCLES, 32, idle cycles after the start write before the first C read; must be ≥ 4*DIM

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  request one multiply
- cmd_ready  out  1  high only in IDLE
- cmd_clr  in  1  sampled with the command; 1 zeroes C before the run
- in_valid  in  1  operand word valid
- in_ready  out  1  operand word accepted when in_valid & in_ready
- in_data  in  DATAW  DIM A rows (row 0 first), then DIM B words
- out_valid  out  1  C word valid
- out_ready  in  1  consumer accepts C word
- out_data  out  DATAW  C word: row r low half, then row r high half, r = 0..DIM-1
- out_last  out  1  marks the final C word (row DIM-1 high)
- tpu_r_w  out  1  1 = write, 0 = read
- tpu_addr  out  ADDRW  tpuv1 address
- tpu_dataIn  out  DATAW  tpuv1 write data
- tpu_dataOut  in  DATAW  tpuv1 read data; combinational from tpu_addr
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after the last C word is accepted

## Operation
Address map driven:
- A row r: 0x100 + 8r
- B: 0x200
- C row r: 0x300 + 16r (low), 0x308 + 16r (high)
- start: 0x400

Idle bus value, used whenever no access is issued: r_w = 0, addr = 0x000, dataIn = 0.

States and transitions:
- IDLE: cmd_ready = 1. On cmd_valid, go to CLR if cmd_clr = 1, else LD_A. Clear idx.
- CLR: write 0 to each of the 2*DIM C addresses, one per cycle in order row0 low, row0 high, …; then LD_A. Consumes no input.
- LD_A: in_ready = 1. tpu_r_w = in_valid, addr = 0x100 + 8·idx, dataIn = in_data, all combinational pass-through. idx advances on each handshake. After DIM handshakes go to LD_B.
- LD_B: same as LD_A, addr = 0x200. After DIM handshakes go to START.
- START: one cycle, write addr 0x400 with dataIn = 0. Then go to WAIT with the wait counter = 0.
- WAIT: idle bus. Counter increments each cycle. On counter = COMPUTE_CYCLES − 1, go to RD_C.
- RD_C: r_w = 0, addr = current C address. When the output register is empty or is handshaking this cycle, capture tpu_dataOut into out_data, set out_valid, advance idx. out_last is set with the 2*DIM-th capture. Stay in RD_C until the out_last word handshakes; then go to DONE.
- DONE: done = 1 for one cycle, then IDLE.

Rules:
- in_ready = 0 outside LD_A and LD_B. Input stalls (in_valid = 0) leave the idle bus and do not advance idx.
- out_valid holds with out_data stable until out_ready; a single output register gives full throughput with no bubble.
- cmd_valid outside IDLE is ignored (cmd_ready = 0). No command queue.
- Extra in_data words beyond 2*DIM are not accepted until the next command.

## Timing
- Reset values: cmd_ready = 0 during reset, then 1 (IDLE). in_ready, out_valid, out_last, busy and done = 0. out_data = 0. Bus at the idle value. All state and counters = 0.
- Reset asserted mid-operation: abort immediately to IDLE, drop out_valid, no done. tpuv1 must be reset in the same event; this block does not restore its state.
- Minimum command latency with cmd_clr = 0 and no stalls:
  - 1 cycle accept (IDLE)
  - 2*DIM cycles load
  - 1 cycle START
  - COMPUTE_CYCLES cycles WAIT
  - 2*DIM cycles C read
  - done 1 cycle after the last out handshake
- cmd_clr adds 2*DIM cycles.
- The bus carries at most one access per cycle. A write occurs only in the cycle its r_w = 1.
- Back-to-back: a command may be accepted in the cycle after DONE.

## Test plan
- A = identity, B = rows of 1..8 (int8), cmd_clr = 1, out_ready = 1 → 16 words. C row r equals B row r in 16-bit lanes; out_last on word 16; done one cycle later.
- Same run with cmd_clr = 0 repeated twice → second result = 2× the first, confirming accumulation without clear.
- out_ready toggled 1-0-1-0 in RD_C → no word lost or duplicated; out_data stable while stalled; read addresses step 0x300, 0x308, 0x310 … 0x378.
- in_valid with random 50% bubbles during loads → tpu write addresses exactly 0x100, 0x108 … 0x138, then 0x200 ×8; r_w = 0 on bubble cycles.
- cmd_valid pulsed while busy → ignored; a second command after done → accepted next cycle.
- rst asserted during WAIT (counter = 10) → busy, out_valid and bus outputs zero asynchronously; IDLE after release; a fresh full run gives the correct result.

Source files
------------

// File: rtl/tpu_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_mm_sequencer
//
// Runs one complete DIM x DIM matrix multiply on the tpuv1 MMIO bus and is
// the only master of that bus. The host sends a command and then a stream of
// operand words. It receives C back as a stream. It never sees an address.
//
// Sequence: [clear C] -> load A rows -> load B words -> start ->
//           fixed compute wait -> read C back -> done pulse.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       request one multiply (accepted only in IDLE)
//   cmd_clr                   sampled with the command; zero C first
//   in_valid/in_ready/in_data operand stream: DIM A rows, then DIM B words
//   out_valid/out_ready/      C stream: row r low word, then row r high word;
//   out_data/out_last         out_last marks the final word
//   tpu_r_w/tpu_addr/         tpuv1 bus (1 = write); tpu_dataOut is
//   tpu_dataIn/tpu_dataOut    combinational read data for tpu_addr
//   busy                      sequencer not idle
//   done                      one-cycle pulse after the last C word leaves
// ---------------------------------------------------------------------------
module tpu_mm_sequencer #(
    parameter int DIM            = 8,
    parameter int DATAW          = 64,
    parameter int ADDRW          = 16,
    parameter int COMPUTE_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut,
    output logic             busy,
    output logic             done
);

    // Number of 64-bit C words: each C row is two bus words.
    localparam int NC    = 2 * DIM;
    localparam int IDXW  = $clog2(NC + 1);
    localparam int WAITW = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_LD_A  = 3'd2;
    localparam logic [2:0] S_LD_B  = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_RD_C  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [IDXW-1:0]  IDX_ZERO     = IDXW'(0);
    localparam logic [IDXW-1:0]  IDX_ONE      = IDXW'(1);
    localparam logic [IDXW-1:0]  IDX_LAST_ROW = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0]  IDX_LAST_C   = IDXW'(NC - 1);
    localparam logic [IDXW-1:0]  IDX_NC       = IDXW'(NC);
    localparam logic [WAITW-1:0] WAIT_ZERO    = WAITW'(0);
    localparam logic [WAITW-1:0] WAIT_ONE     = WAITW'(1);
    localparam logic [WAITW-1:0] WAIT_LAST    = WAITW'(COMPUTE_CYCLES - 1);

    localparam logic [ADDRW-1:0] ADDR_IDLE  = ADDRW'(16'h000);
    localparam logic [ADDRW-1:0] ADDR_A     = ADDRW'(16'h100);
    localparam logic [ADDRW-1:0] ADDR_B     = ADDRW'(16'h200);
    localparam logic [ADDRW-1:0] ADDR_C     = ADDRW'(16'h300);
    localparam logic [ADDRW-1:0] ADDR_START = ADDRW'(16'h400);

    localparam logic [DATAW-1:0] DATA_ZERO = {DATAW{1'b0}};

    logic [2:0]       state_r, state_s;
    logic [IDXW-1:0]  idx_r, idx_s;
    logic [WAITW-1:0] wait_r, wait_s;
    logic             out_valid_r;
    logic             out_last_r;
    logic [DATAW-1:0] out_data_r;

    logic             in_ready_s;
    logic             ld_hs_s;
    logic             c_left_s;
    logic             capture_s;
    logic             out_hs_s;
    logic [ADDRW-1:0] word_off_s;
    logic             bus_r_w_s;
    logic [ADDRW-1:0] bus_addr_s;
    logic [DATAW-1:0] bus_data_s;

    assign in_ready_s = (state_r == S_LD_A) || (state_r == S_LD_B);
    assign ld_hs_s    = in_valid && in_ready_s;
    // idx walks C words 0..NC-1 during readback; NC means all captured.
    assign c_left_s   = (idx_r < IDX_NC);
    // Single output register: refill in the same cycle the consumer drains it.
    assign out_hs_s   = out_valid_r && out_ready;
    assign capture_s  = (state_r == S_RD_C) && c_left_s && (!out_valid_r || out_ready);
    // Both A rows and C words sit 8 bytes apart, so one offset serves both.
    assign word_off_s = ADDRW'(idx_r) << 3;

    // Bus drive: pass-through during loads, otherwise derived from state/idx.
    always_comb begin
        bus_r_w_s  = 1'b0;
        bus_addr_s = ADDR_IDLE;
        bus_data_s = DATA_ZERO;
        case (state_r)
            S_CLR: begin
                bus_r_w_s  = 1'b1;
                bus_addr_s = ADDR_C + word_off_s;
            end
            S_LD_A: begin
                if (in_valid) begin
                    bus_r_w_s  = 1'b1;
                    bus_addr_s = ADDR_A + word_off_s;
                    bus_data_s = in_data;
                end else begin
                    bus_r_w_s  = 1'b0;
                    bus_addr_s = ADDR_IDLE;
                    bus_data_s = DATA_ZERO;
                end
            end
            S_LD_B: begin
                if (in_valid) begin
                    bus_r_w_s  = 1'b1;
                    bus_addr_s = ADDR_B;
                    bus_data_s = in_data;
                end else begin
                    bus_r_w_s  = 1'b0;
                    bus_addr_s = ADDR_IDLE;
                    bus_data_s = DATA_ZERO;
                end
            end
            S_START: begin
                bus_r_w_s  = 1'b1;
                bus_addr_s = ADDR_START;
            end
            S_RD_C: begin
                if (c_left_s) begin
                    bus_addr_s = ADDR_C + word_off_s;
                end else begin
                    bus_addr_s = ADDR_IDLE;
                end
            end
            default: begin
                bus_r_w_s  = 1'b0;
                bus_addr_s = ADDR_IDLE;
                bus_data_s = DATA_ZERO;
            end
        endcase
    end

    // Next-state, word index and compute-wait counter.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        wait_s  = wait_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_s = cmd_clr ? S_CLR : S_LD_A;
                    idx_s   = IDX_ZERO;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLR: begin
                if (idx_r == IDX_LAST_C) begin
                    state_s = S_LD_A;
                    idx_s   = IDX_ZERO;
                end else begin
                    idx_s = idx_r + IDX_ONE;
                end
            end
            S_LD_A: begin
                if (ld_hs_s && (idx_r == IDX_LAST_ROW)) begin
                    state_s = S_LD_B;
                    idx_s   = IDX_ZERO;
                end else if (ld_hs_s) begin
                    idx_s = idx_r + IDX_ONE;
                end else begin
                    idx_s = idx_r;
                end
            end
            S_LD_B: begin
                if (ld_hs_s && (idx_r == IDX_LAST_ROW)) begin
                    state_s = S_START;
                    idx_s   = IDX_ZERO;
                end else if (ld_hs_s) begin
                    idx_s = idx_r + IDX_ONE;
                end else begin
                    idx_s = idx_r;
                end
            end
            S_START: begin
                state_s = S_WAIT;
                wait_s  = WAIT_ZERO;
            end
            S_WAIT: begin
                if (wait_r == WAIT_LAST) begin
                    state_s = S_RD_C;
                    idx_s   = IDX_ZERO;
                end else begin
                    wait_s = wait_r + WAIT_ONE;
                end
            end
            S_RD_C: begin
                if (out_hs_s && out_last_r) begin
                    state_s = S_DONE;
                end else if (capture_s) begin
                    idx_s = idx_r + IDX_ONE;
                end else begin
                    idx_s = idx_r;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = IDX_ZERO;
                wait_s  = WAIT_ZERO;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            idx_r   <= IDX_ZERO;
            wait_r  <= WAIT_ZERO;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            wait_r  <= wait_s;
        end
    end

    // Output holding register: capture read data, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= DATA_ZERO;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= (idx_r == IDX_LAST_C);
            out_data_r  <= tpu_dataOut;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    // cmd_ready is gated by rst so it reads 0 while reset is held.
    assign cmd_ready  = (state_r == S_IDLE) && !rst;
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign tpu_r_w    = bus_r_w_s;
    assign tpu_addr   = bus_addr_s;
    assign tpu_dataIn = bus_data_s;
    assign busy       = (state_r != S_IDLE);
    assign done       = (state_r == S_DONE);

endmodule

// File: tb/tb_tpu_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tpu_mm_sequencer
//
// Self-checking bench for tpu_mm_sequencer with a behavioural tpuv1 stub.
// Expected bus writes and expected C words are queued when a command is
// issued. A negedge monitor pops and compares them as the DUT produces them.
// C values come from an integer matrix model built from the host operands.
// ---------------------------------------------------------------------------
module tb_tpu_mm_sequencer;

    localparam int DIM   = 8;
    localparam int DATAW = 64;
    localparam int ADDRW = 16;
    localparam int CC    = 32;
    localparam int NC    = 2 * DIM;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_clr;
    logic             in_valid, in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid, out_ready, out_last;
    logic [DATAW-1:0] out_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn, tpu_dataOut;
    logic             busy, done;

    int n_checks = 0;
    int n_err    = 0;
    int rdy_mode = 0;

    always #5 clk = ~clk;

    tpu_mm_sequencer #(.DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clr(cmd_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut),
        .busy(busy), .done(done)
    );

    // ---------------- tpuv1 stub ----------------
    logic [63:0] a_mem [DIM];
    logic [63:0] b_mem [DIM];
    logic [63:0] c_mem [NC];
    int          b_cnt;

    function automatic logic [63:0] new_c_word(int w);
        logic [63:0]        v;
        logic [15:0]        s;
        logic signed [15:0] pa, pb;
        int                 r, j;
        r = w / 2;
        v = c_mem[w];
        for (int l = 0; l < 4; l++) begin
            j = 4 * (w % 2) + l;
            s = v[16*l +: 16];
            for (int k = 0; k < DIM; k++) begin
                pa = $signed(a_mem[r][8*k +: 8]);
                pb = $signed(b_mem[k][8*j +: 8]);
                s  = s + 16'(pa * pb);
            end
            v[16*l +: 16] = s;
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) c_mem[i] <= 64'd0;
            for (int i = 0; i < DIM; i++) begin
                a_mem[i] <= 64'd0;
                b_mem[i] <= 64'd0;
            end
            b_cnt <= 0;
        end else if (tpu_r_w) begin
            if (tpu_addr >= 16'h100 && tpu_addr < 16'h140)
                a_mem[int'((tpu_addr - 16'h100) >> 3)] <= tpu_dataIn;
            else if (tpu_addr == 16'h200) begin
                b_mem[b_cnt % DIM] <= tpu_dataIn;
                b_cnt <= b_cnt + 1;
            end else if (tpu_addr >= 16'h300 && tpu_addr < 16'h380)
                c_mem[int'((tpu_addr - 16'h300) >> 3)] <= tpu_dataIn;
            else if (tpu_addr == 16'h400) begin
                for (int w = 0; w < NC; w++) c_mem[w] <= new_c_word(w);
                b_cnt <= 0;
            end
        end
    end

    always_comb begin
        tpu_dataOut = 64'd0;
        if (tpu_addr >= 16'h300 && tpu_addr < 16'h380 && tpu_addr[2:0] == 3'd0)
            tpu_dataOut = c_mem[int'((tpu_addr - 16'h300) >> 3)];
    end

    // ---------------- reference model and scoreboards ----------------
    int          ma [DIM][DIM];
    int          mb [DIM][DIM];
    int          mc [DIM][DIM];
    logic [15:0] exp_addr_q [$];
    logic [63:0] exp_wdata_q [$];
    logic [63:0] exp_out_q [$];
    logic        exp_last_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] a_word(int r);
        logic [63:0] w;
        for (int k = 0; k < DIM; k++) w[8*k +: 8] = 8'(ma[r][k]);
        return w;
    endfunction

    function automatic logic [63:0] b_word(int k);
        logic [63:0] w;
        for (int j = 0; j < DIM; j++) w[8*j +: 8] = 8'(mb[k][j]);
        return w;
    endfunction

    function automatic logic [63:0] c_exp_word(int w);
        logic [63:0] v;
        for (int l = 0; l < 4; l++) v[16*l +: 16] = 16'(mc[w/2][4*(w%2) + l]);
        return v;
    endfunction

    // out_ready pattern: 0 = always ready, 1 = alternate, 2 = random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ~out_ready;
            else                    out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: bus writes, C stream, stall hold, no-bubble, done, compute wait.
    initial begin
        int          cyc = 0;
        int          start_cyc = 0;
        bit          stall_prev = 0, hs_prev = 0, last_prev = 0, wait_chk = 0;
        logic [63:0] held = 64'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 0; hs_prev = 0; last_prev = 0; wait_chk = 0;
            end else begin
                if (stall_prev) begin
                    chk("out_hold_valid", 64'(out_valid), 64'd1);
                    chk("out_hold_data", out_data, held);
                end
                if (hs_prev) chk("out_no_bubble", 64'(out_valid), 64'd1);
                if (last_prev) chk("done_after_last", 64'(done), 64'd1);
                else if (done) chk("done_unexpected", 64'(done), 64'd0);
                if (tpu_r_w) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("bus_unexpected_write", 64'(tpu_r_w), 64'd0);
                    end else begin
                        chk("bus_addr", 64'(tpu_addr), 64'(exp_addr_q.pop_front()));
                        chk("bus_wdata", tpu_dataIn, exp_wdata_q.pop_front());
                    end
                    if (tpu_addr == 16'h400) begin
                        start_cyc = cyc;
                        wait_chk  = 1;
                    end
                end else begin
                    chk("idle_dataIn", tpu_dataIn, 64'd0);
                end
                if (wait_chk && out_valid) begin
                    chk("compute_wait", 64'(cyc - start_cyc), 64'(CC + 2));
                    wait_chk = 0;
                end
                stall_prev = out_valid && !out_ready;
                held       = out_data;
                hs_prev    = out_valid && out_ready && !out_last;
                last_prev  = out_valid && out_ready && out_last;
                if (out_valid && out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        chk("out_unexpected", 64'(out_valid), 64'd0);
                    end else begin
                        chk("out_data", out_data, exp_out_q.pop_front());
                        chk("out_last", 64'(out_last), 64'(exp_last_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic drive_word(input logic [63:0] data, input bit bubbles);
        int t  = 0;
        bit hs = 0;
        while (!hs && t < 300) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? data : {$urandom, $urandom};
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) chk("load_timeout", 64'(hs), 64'd1);
    endtask

    task automatic run_cmd(input bit clr, input bit bubbles, input bit poke, input bit abort);
        int t;
        if (clr) begin
            for (int i = 0; i < NC; i++) begin
                exp_addr_q.push_back(16'(16'h300 + 8 * i));
                exp_wdata_q.push_back(64'd0);
            end
        end
        for (int r = 0; r < DIM; r++) begin
            exp_addr_q.push_back(16'(16'h100 + 8 * r));
            exp_wdata_q.push_back(a_word(r));
        end
        for (int k = 0; k < DIM; k++) begin
            exp_addr_q.push_back(16'h200);
            exp_wdata_q.push_back(b_word(k));
        end
        exp_addr_q.push_back(16'h400);
        exp_wdata_q.push_back(64'd0);
        // C = (clr ? 0 : C) + A*B
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) begin
                if (clr) mc[r][j] = 0;
                for (int k = 0; k < DIM; k++) mc[r][j] += ma[r][k] * mb[k][j];
            end
        for (int w = 0; w < NC; w++) begin
            exp_out_q.push_back(c_exp_word(w));
            exp_last_q.push_back(w == NC - 1);
        end

        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_clr   = clr;
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
        for (int i = 0; i < NC; i++) drive_word(i < DIM ? a_word(i) : b_word(i - DIM), bubbles);
        in_valid = 1'b0;

        if (poke) begin
            in_valid  = 1'b1;
            in_data   = {$urandom, $urandom};
            cmd_valid = 1'b1;
            cmd_clr   = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
                chk("busy_in_ready", 64'(in_ready), 64'd0);
                chk("busy_flag", 64'(busy), 64'd1);
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            cmd_valid = 1'b0;
            cmd_clr   = 1'b0;
        end

        if (abort) begin
            @(negedge clk);
            chk("start_write_addr", 64'(tpu_addr), 64'h400);
            repeat (11) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_out_valid", 64'(out_valid), 64'd0);
            chk("abort_bus", {47'd0, tpu_r_w, tpu_addr}, 64'd0);
            chk("abort_dataIn", tpu_dataIn, 64'd0);
            chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
            exp_addr_q.delete();
            exp_wdata_q.delete();
            exp_out_q.delete();
            exp_last_q.delete();
            for (int r = 0; r < DIM; r++)
                for (int j = 0; j < DIM; j++) mc[r][j] = 0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("post_abort_idle", 64'(cmd_ready), 64'd1);
            chk("post_abort_done", 64'(done), 64'd0);
        end else begin
            t = 0;
            @(negedge clk);
            while (done !== 1'b1 && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("done_seen", 64'(done), 64'd1);
        end
    endtask

    task automatic rand_mats();
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                ma[r][k] = int'($urandom_range(0, 255)) - 128;
                mb[r][k] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) mc[r][j] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_bus", {47'd0, tpu_r_w, tpu_addr}, 64'd0);
        chk("rst_dataIn", tpu_dataIn, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // Identity A, distinct B rows: C row r = B row r
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                ma[r][k] = (r == k) ? 1 : 0;
                mb[r][k] = 8 * r + k + 1;
            end
        rdy_mode = 0;
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        // Accumulate without clear twice: 2x then 3x, back to back
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        // Random operands, alternating out_ready, input bubbles
        rand_mats();
        rdy_mode = 1;
        run_cmd(1'b1, 1'b1, 1'b0, 1'b0);
        rand_mats();
        rdy_mode = 2;
        run_cmd(1'b0, 1'b1, 1'b1, 1'b0);
        // Reset during WAIT, then a fresh run
        rand_mats();
        rdy_mode = 0;
        run_cmd(1'b1, 1'b0, 1'b0, 1'b1);
        rand_mats();
        rdy_mode = 2;
        run_cmd(1'b0, 1'b1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("bus_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("out_queue_drained", 64'(exp_out_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
